snoop_cache_ctrl: RTL and testbench
===================================

Name: snoop_cache_ctrl

Overview:
- Per-processor snooping cache controller: the initiator side of the 11-bit snooping bus whose responder is the shared memory block.
- Holds one direct-mapped line (1-bit address tag, 3-bit data) with MSI state.
- Services processor read and write requests, issues read_miss, write_miss and invalidate on the bus, and consumes the memory reply.
- Snoops other caches' requests and downgrades or invalidates its own line.

Parameters:
- CPU_ID, 2'b00, identity driven on bus bits [9:8] and matched on replies.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  processor request strobe, sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  1  word address (0 or 1)
- cpu_wdata  in  3  write data
- cpu_rdata  out  3  read data, valid while cpu_ready = 1
- cpu_ready  out  1  one-cycle completion pulse
- barramentoIn  in  11  merged bus view (memory replies plus other caches' requests)
- barramentoOut  out  11  this cache's bus message
- line_state  out  2  MSI state, for debug and verification

Behaviour:
- Bus word fields:
  - [10] source: 1 = cache, 0 = memory.
  - [9:8] requester ID.
  - [7:6] reserved, always 0.
  - [5:4] op: 00 read_miss, 01 write_miss, 10 invalidate, 11 empty.
  - [3] address.
  - [2:0] data.
- Idle bus word: 11'b00000110000 (op = empty, all other fields 0).
- MSI encoding on line_state: 00 INVALID, 01 SHARED, 10 MODIFIED.
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - line INVALID; tag 0; data 0.
  - FSM to IDLE; cpu_ready 0; cpu_rdata 0; barramentoOut = idle word.
- All outputs are registered.
- FSM states: IDLE, RM_ISSUE, RM_WAIT, WM_ISSUE, INV_ISSUE, DONE.
- In IDLE with cpu_req = 1, request fields are latched. Hit means line is not INVALID and tag == cpu_addr.
  - Read hit: go to DONE. cpu_rdata = line data; cpu_ready pulses 1 cycle after acceptance.
  - Write hit, line MODIFIED: write data, go to DONE. No bus traffic.
  - Write hit, line SHARED: go to INV_ISSUE.
  - Read miss: go to RM_ISSUE.
  - Write miss: go to WM_ISSUE. This includes a tag mismatch on a valid line. A victim in MODIFIED is dropped without writeback; the memory model has no write path.
- RM_ISSUE: drive one cycle of {1, CPU_ID, 00, 00, addr, 000}, then idle word; go to RM_WAIT.
- RM_WAIT: wait for a memory reply: [10] = 0, op = empty, [9:8] = CPU_ID, [3] = latched addr.
  - On the reply: fill tag and data, line SHARED, cpu_rdata = reply data, go to DONE.
  - The reply arrives 2 cycles after the request is driven.
  - No timeout; the FSM waits indefinitely.
- WM_ISSUE: drive one cycle of {1, CPU_ID, 00, 01, addr, wdata}. Write tag and data, line MODIFIED, go to DONE.
- INV_ISSUE: drive one cycle of {1, CPU_ID, 00, 10, addr, wdata}. Write data, line MODIFIED, go to DONE.
- DONE: cpu_ready = 1 for exactly one cycle, then IDLE. cpu_rdata holds until the next completion.
- Snooping applies in every FSM state, to messages with [10] = 1, [9:8] != CPU_ID and [3] == tag while the line is valid:
  - remote read_miss, line MODIFIED -> SHARED;
  - remote write_miss or invalidate -> INVALID;
  - memory-sourced words ([10] = 0) are never snooped; an all-zero word from memory is not a read_miss.
- Simultaneous events:
  - A snoop and a local state update in the same cycle: the snoop is evaluated first and the local update applies after it.
  - A line invalidated while the FSM is in INV_ISSUE: the message sent becomes write_miss (op 01) instead of invalidate.
- cpu_req is ignored outside IDLE.

Test Plan:
- Reset, CPU_ID=1, read addr 0; memory replies {0,01,00,11,0,001} -> barramentoOut read_miss {1,01,00,00,0,000} for one cycle; cpu_ready pulses with cpu_rdata = 3'b001; line_state = SHARED.
- Then read addr 0 again -> cpu_ready 1 cycle after acceptance, cpu_rdata = 001, no bus traffic (barramentoOut stays idle word).
- Line SHARED, write 3'b110 to addr 0 -> invalidate {1,01,00,10,0,110}; line_state = MODIFIED; subsequent read returns 110 with no bus traffic.
- Line MODIFIED addr 0; bus drives remote read_miss {1,10,00,00,0,000} -> line_state SHARED. Remote write_miss to addr 0 -> INVALID. The same messages with addr 1, or with [10] = 0, cause no change.
- Write 3'b011 to addr 1 while holding a valid line at addr 0 -> write_miss {1,01,00,01,1,011}; tag 1; MODIFIED; no reply awaited.
- Assert reset_n = 0 while in RM_WAIT -> immediate idle word, INVALID, cpu_ready 0. A late memory reply after release is ignored.

Source files
------------

// File: rtl/snoop_cache_ctrl.sv
// snoop_cache_ctrl: per-processor MSI snooping cache controller holding one
// direct-mapped line (1-bit tag, 3-bit data). It is the initiator side of the
// 11-bit snooping bus; the shared memory block is the responder.
//
// Ports:
//   clock         system clock, rising edge
//   reset_n       asynchronous active-low reset
//   cpu_req       processor request strobe (sampled only in IDLE)
//   cpu_we        1 = write, 0 = read
//   cpu_addr      word address (0/1)
//   cpu_wdata     write data
//   cpu_rdata     read data, valid while cpu_ready = 1
//   cpu_ready     one-cycle completion pulse
//   barramentoIn  merged bus view (memory replies + other caches' requests)
//   barramentoOut this cache's bus message (idle word when silent)
//   line_state    MSI state of the line (00 I, 01 S, 10 M)
//
// Bus word: [10] src (1 cache / 0 memory), [9:8] requester ID, [7:6] 0,
//           [5:4] op (00 RM, 01 WM, 10 INV, 11 empty), [3] addr, [2:0] data.
module snoop_cache_ctrl #(
  parameter logic [1:0] CPU_ID = 2'b00
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_addr,
  input  logic [2:0]  cpu_wdata,
  output logic [2:0]  cpu_rdata,
  output logic        cpu_ready,
  input  logic [10:0] barramentoIn,
  output logic [10:0] barramentoOut,
  output logic [1:0]  line_state
);

  typedef enum logic [1:0] {
    INVALID  = 2'b00,
    SHARED   = 2'b01,
    MODIFIED = 2'b10
  } msi_t;

  typedef enum logic [2:0] {
    IDLE, RM_ISSUE, RM_WAIT, WM_ISSUE, INV_ISSUE, DONE
  } state_t;

  localparam logic [1:0]  OP_RM     = 2'b00;
  localparam logic [1:0]  OP_WM     = 2'b01;
  localparam logic [1:0]  OP_INV    = 2'b10;
  localparam logic [1:0]  OP_EMPTY  = 2'b11;
  localparam logic [10:0] IDLE_WORD = 11'b000_0011_0000;

  state_t     state;
  msi_t       line;
  msi_t       snooped;
  logic       tag;
  logic [2:0] data;
  logic       req_we;
  logic       req_addr;
  logic [2:0] req_wdata;
  logic       hit;
  logic       reply;
  logic [1:0] bus_op;

  assign bus_op     = barramentoIn[5:4];
  assign line_state = line;

  // Line state after applying the snoop of this cycle's bus word; every local
  // update below is layered on top of this value.
  always_comb begin
    snooped = line;
    if (barramentoIn[10] && (barramentoIn[9:8] != CPU_ID) &&
        (line != INVALID) && (barramentoIn[3] == tag)) begin
      case (bus_op)
        OP_RM:         if (line == MODIFIED) snooped = SHARED;
        OP_WM, OP_INV: snooped = INVALID;
        default:       snooped = line;
      endcase
    end
  end

  assign hit   = (snooped != INVALID) && (tag == cpu_addr);
  assign reply = !barramentoIn[10] && (bus_op == OP_EMPTY) &&
                 (barramentoIn[9:8] == CPU_ID) && (barramentoIn[3] == req_addr);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      line          <= INVALID;
      tag           <= 1'b0;
      data          <= '0;
      req_we        <= 1'b0;
      req_addr      <= 1'b0;
      req_wdata     <= '0;
      cpu_rdata     <= '0;
      cpu_ready     <= 1'b0;
      barramentoOut <= IDLE_WORD;
    end else begin
      line      <= snooped;
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_we    <= cpu_we;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            if (!cpu_we && hit) begin
              cpu_rdata <= data;
              cpu_ready <= 1'b1;
              state     <= DONE;
            end else if (cpu_we && hit && (snooped == MODIFIED)) begin
              data      <= cpu_wdata;
              cpu_ready <= 1'b1;
              state     <= DONE;
            end else if (cpu_we && hit) begin
              state <= INV_ISSUE;
            end else if (!cpu_we) begin
              state <= RM_ISSUE;
            end else begin
              state <= WM_ISSUE;
            end
          end
        end
        RM_ISSUE: begin
          barramentoOut <= {1'b1, CPU_ID, 2'b00, OP_RM, req_addr, 3'b000};
          state         <= RM_WAIT;
        end
        RM_WAIT: begin
          barramentoOut <= IDLE_WORD;
          if (reply) begin
            tag       <= req_addr;
            data      <= barramentoIn[2:0];
            line      <= SHARED;
            cpu_rdata <= barramentoIn[2:0];
            cpu_ready <= 1'b1;
            state     <= DONE;
          end
        end
        WM_ISSUE: begin
          barramentoOut <= {1'b1, CPU_ID, 2'b00, OP_WM, req_addr, req_wdata};
          tag           <= req_addr;
          data          <= req_wdata;
          line          <= MODIFIED;
          cpu_ready     <= 1'b1;
          state         <= DONE;
        end
        INV_ISSUE: begin
          // A copy lost to a concurrent remote snoop must be re-acquired, so
          // the upgrade goes out as a write_miss instead of an invalidate.
          barramentoOut <= {1'b1, CPU_ID, 2'b00,
                            (snooped == INVALID) ? OP_WM : OP_INV,
                            req_addr, req_wdata};
          tag           <= req_addr;
          data          <= req_wdata;
          line          <= MODIFIED;
          cpu_ready     <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          barramentoOut <= IDLE_WORD;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_cache_ctrl.sv
// Testbench for snoop_cache_ctrl: directed scenarios followed by random CPU
// requests and remote bus messages. Expected bus messages and read data are
// queued when stimulus is issued; a monitor pops and compares them whenever
// the DUT raises cpu_ready or drives a non-idle bus word.
module tb_snoop_cache_ctrl;

  localparam logic [1:0]  ID     = 2'b01;
  localparam logic [10:0] IDLE_W = 11'b00000110000;

  logic        clock;
  logic        reset_n;
  logic        cpu_req;
  logic        cpu_we;
  logic        cpu_addr;
  logic [2:0]  cpu_wdata;
  logic [2:0]  cpu_rdata;
  logic        cpu_ready;
  logic [10:0] barramentoIn;
  logic [10:0] barramentoOut;
  logic [1:0]  line_state;

  snoop_cache_ctrl #(.CPU_ID(ID)) dut (
    .clock(clock), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .barramentoIn(barramentoIn),
    .barramentoOut(barramentoOut), .line_state(line_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_vec = 0;
  int          n_err = 0;
  int          rq[$];        // expected cpu_rdata per completion, -1 = don't care
  logic [10:0] bq[$];        // expected non-idle bus words, in order

  // Reference model: MSI line as plain integers, memory contents fixed.
  int          m_state;      // 0 invalid, 1 shared, 2 modified
  int          m_tag;
  int          m_data;
  logic [2:0]  mem [2];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every completion and every bus message must match the queues.
  initial begin
    int          e;
    logic [10:0] eb;
    forever begin
      @(negedge clock);
      if (reset_n === 1'b1) begin
        if (cpu_ready === 1'b1) begin
          if (rq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_ready: rdata=%0d, no completion expected", cpu_rdata);
          end else begin
            e = rq.pop_front();
            if (e >= 0) chk("cpu_rdata", int'(cpu_rdata), e);
          end
        end
        if (barramentoOut !== IDLE_W) begin
          if (bq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_bus: got %b, expected idle word", barramentoOut);
          end else begin
            eb = bq.pop_front();
            chk("bus_msg", int'(barramentoOut), int'(eb));
          end
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (cpu_ready === 1'b1) ok = 1;
      else @(negedge clock);
    end
    if (!ok) chk({name, "_ready_timeout"}, 0, 1);
  endtask

  task automatic wait_bus(input logic [10:0] msg, output bit ok);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (barramentoOut === msg) ok = 1;
      else @(negedge clock);
    end
    if (!ok) chk("bus_timeout", 0, 1);
  endtask

  // One CPU request, run to completion; optionally a remote invalidate is
  // injected during the cycle after acceptance (upgrade race).
  task automatic cpu_op(input bit we, input bit a, input logic [2:0] d,
                        input bit race);
    bit          hit = (m_state != 0) && (m_tag == int'(a));
    bit          ok;
    logic [10:0] rm;
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    if (!we) begin
      if (hit) rq.push_back(m_data);
      else begin
        rm = {1'b1, ID, 2'b00, 2'b00, a, 3'b000};
        bq.push_back(rm);
        rq.push_back(int'(mem[a]));
      end
    end else begin
      rq.push_back(-1);
      if (hit && m_state == 2) m_data = int'(d);
      else begin
        bq.push_back({1'b1, ID, 2'b00, (hit && !race) ? 2'b10 : 2'b01, a, d});
        m_tag = int'(a); m_data = int'(d); m_state = 2;
      end
    end
    @(negedge clock);
    cpu_req = 1'b0;
    if (race) begin
      barramentoIn = {1'b1, 2'b10, 2'b00, 2'b10, a, 3'b000};
      @(negedge clock);
      barramentoIn = IDLE_W;
    end
    if (!we && !hit) begin
      wait_bus(rm, ok);
      if (ok) begin
        @(negedge clock);
        barramentoIn = {1'b0, ID, 2'b00, 2'b11, a, mem[a]};
        @(negedge clock);
        barramentoIn = IDLE_W;
      end
      m_tag = int'(a); m_data = int'(mem[a]); m_state = 1;
    end
    wait_ready(we ? "write" : "read");
    @(negedge clock);
    chk("line_state_after_cpu", int'(line_state), m_state);
  endtask

  task automatic remote(input bit src, input logic [1:0] id,
                        input logic [1:0] op, input bit a);
    @(negedge clock);
    barramentoIn = {src, id, 2'b00, op, a, 3'($urandom_range(7))};
    @(negedge clock);
    barramentoIn = IDLE_W;
    if (src && id != ID && m_state != 0 && m_tag == int'(a)) begin
      if (op == 2'b00 && m_state == 2) m_state = 1;
      else if (op == 2'b01 || op == 2'b10) m_state = 0;
    end
    chk("line_state_after_snoop", int'(line_state), m_state);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    logic [10:0] rm;
    mem[0] = 3'b001;
    mem[1] = 3'($urandom_range(7));
    reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 1'b0;
    cpu_wdata = '0; barramentoIn = IDLE_W;
    m_state = 0; m_tag = 0; m_data = 0;
    repeat (2) @(negedge clock);
    chk("reset_line_state", int'(line_state), 0);
    chk("reset_ready", int'(cpu_ready), 0);
    chk("reset_rdata", int'(cpu_rdata), 0);
    chk("reset_bus", int'(barramentoOut), int'(IDLE_W));
    reset_n = 1'b1;

    // Directed: read miss, read hit, upgrade, snoops, write miss.
    cpu_op(0, 0, 3'b000, 0);
    cpu_op(0, 0, 3'b000, 0);
    cpu_op(1, 0, 3'b110, 0);
    cpu_op(0, 0, 3'b000, 0);
    remote(1, 2'b10, 2'b00, 1);
    remote(0, 2'b10, 2'b00, 0);
    remote(1, ID,    2'b00, 0);
    remote(1, 2'b10, 2'b00, 0);
    remote(1, 2'b10, 2'b01, 1);
    remote(0, 2'b10, 2'b01, 0);
    remote(1, 2'b10, 2'b01, 0);
    cpu_op(0, 0, 3'b000, 0);
    cpu_op(1, 1, 3'b011, 0);
    // Upgrade of a shared line racing a remote invalidate.
    cpu_op(0, 0, 3'b000, 0);
    cpu_op(1, 0, 3'b101, 1);

    // Random mix of CPU requests and remote bus messages.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(9) < 6)
        cpu_op(1'($urandom_range(1)), 1'($urandom_range(1)),
               3'($urandom_range(7)), 0);
      else
        remote(1'($urandom_range(3) != 0), 2'($urandom_range(3)),
               2'($urandom_range(3)), 1'($urandom_range(1)));
    end

    // Reset in the middle of a read miss; the late reply must be ignored.
    if (m_state != 0 && m_tag == 0) remote(1, 2'b10, 2'b01, 0);
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 1'b0;
    rm = {1'b1, ID, 2'b00, 2'b00, 1'b0, 3'b000};
    bq.push_back(rm);
    @(negedge clock);
    cpu_req = 1'b0;
    wait_bus(rm, ok);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midreset_bus", int'(barramentoOut), int'(IDLE_W));
    chk("midreset_line_state", int'(line_state), 0);
    chk("midreset_ready", int'(cpu_ready), 0);
    rq.delete(); bq.delete();
    m_state = 0; m_tag = 0; m_data = 0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    barramentoIn = {1'b0, ID, 2'b00, 2'b11, 1'b0, mem[0]};
    @(negedge clock);
    barramentoIn = IDLE_W;
    repeat (4) @(negedge clock);
    chk("late_reply_line_state", int'(line_state), 0);
    chk("late_reply_rdata", int'(cpu_rdata), 0);
    cpu_op(0, 1, 3'b000, 0);

    repeat (3) @(negedge clock);
    chk("queues_drained", rq.size() + bq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
